// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg -- shared definitions for the iterative divider.
//   DIV_W       operand / result width (32)
//   DIV_ITERS   restoring iterations per divide (32)
//   CNT_W       iteration counter width
//   LAST_ITER   counter value of the final iteration
//   DIV_ZERO_Q  quotient returned for a zero divisor
//   div_state_e FSM encoding: IDLE / CALC / DONE
//   div_op_t    per-operation context captured at start
//   mag33()     33-bit magnitude of a signed/unsigned 32-bit operand
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    localparam logic [CNT_W-1:0] LAST_ITER  = CNT_W'(DIV_ITERS - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic             neg_q;    // operand signs differ (signed only)
        logic             neg_r;    // dividend negative (signed only)
        logic             div_zero; // divisor was zero at start
        logic [DIV_W-1:0] dvd_raw;  // dividend as presented, for /0 result
        logic [DIV_W:0]   div_mag;  // divisor magnitude
    } div_op_t;

    // Sign-extend to 33 bits before negating so that 0x80000000 yields an
    // exact magnitude of 2^31.
    function automatic logic [DIV_W:0] mag33(input logic [DIV_W-1:0] v,
                                             input logic             sgn);
        logic [DIV_W:0] ext;
        ext = {sgn & v[DIV_W-1], v};
        return (sgn && v[DIV_W-1]) ? (~ext + 33'd1) : ext;
    endfunction

endpackage

// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if -- EX-stage <-> divider signal bundle.
//   start, flush, is_signed, dividend, divisor : requester -> divider
//   busy, done, quotient, remainder            : divider -> requester
// Modports: master (EX stage / bench), slave (div_unit).
// -----------------------------------------------------------------------------
interface div_if;
    import div_pkg::*;

    logic             start;
    logic             flush;
    logic             is_signed;
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DIV_W-1:0] quotient;
    logic [DIV_W-1:0] remainder;

    modport master (
        output start, flush, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, flush, is_signed, dividend, divisor,
        output busy, done, quotient, remainder
    );

endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step -- one restoring radix-2 division iteration (combinational).
//   part_rem : shifted partial remainder {rem, next dividend bit}
//   div_mag  : divisor magnitude
//   next_rem : partial remainder after the trial subtraction
//   q_bit    : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W:0] part_rem,
    input  logic [DIV_W:0] div_mag,
    output logic [DIV_W:0] next_rem,
    output logic           q_bit
);

    logic [DIV_W+1:0] diff;

    // Extra MSB acts as the borrow: clear means part_rem >= div_mag.
    always_comb begin
        diff     = {1'b0, part_rem} - {1'b0, div_mag};
        q_bit    = ~diff[DIV_W+1];
        next_rem = q_bit ? diff[DIV_W:0] : part_rem;
    end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- 32-bit iterative restoring divider, signed/unsigned.
//   clk     : clock, rising edge
//   resetn  : asynchronous active-low reset
//   bus     : div_if.slave (start/flush/is_signed/dividend/divisor in,
//             busy/done/quotient/remainder out)
// One quotient bit per cycle; done pulses in the 33rd cycle after the start
// edge. Results are registered and held until the next completed divide.
// Divide by zero returns quotient all-ones, remainder = original dividend.
// Build option: DIV_ZERO_FASTPATH_EN -- a zero divisor skips CALC and goes
// straight to DONE, completing in the first cycle after start.
// -----------------------------------------------------------------------------
module div_unit
    import div_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    div_if.slave bus
);

    div_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    div_op_t          op;

    // acc starts as the dividend magnitude and shifts quotient bits in at
    // the bottom as dividend bits leave at the top.
    logic [DIV_W-1:0] acc;
    logic [DIV_W:0]   rem_r;

    logic [DIV_W-1:0] quo_q, rem_q;
    logic [DIV_W-1:0] res_q_nxt, res_r_nxt;
    logic             capture, step_en, load_res;

    logic [DIV_W:0]   dvd_mag, dsr_mag, part_rem, next_rem;
    logic             q_bit;
    logic [DIV_W-1:0] acc_nxt, q_mag, r_mag, q_fin, r_fin;

    // Remainder stays below the divisor and the dividend magnitude never
    // exceeds 2^32-1, so these top bits are always zero.
    logic zero_bits_unused;
    assign zero_bits_unused = rem_r[DIV_W] | dvd_mag[DIV_W];

    assign dvd_mag  = mag33(bus.dividend, bus.is_signed);
    assign dsr_mag  = mag33(bus.divisor,  bus.is_signed);
    assign part_rem = {rem_r[DIV_W-1:0], acc[DIV_W-1]};

    div_step u_step (
        .part_rem (part_rem),
        .div_mag  (op.div_mag),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    assign acc_nxt = {acc[DIV_W-2:0], q_bit};
    assign q_mag   = acc_nxt;
    assign r_mag   = next_rem[DIV_W-1:0];
    assign q_fin   = op.neg_q ? -q_mag : q_mag;
    assign r_fin   = op.neg_r ? -r_mag : r_mag;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        step_en   = 1'b0;
        load_res  = 1'b0;
        res_q_nxt = quo_q;
        res_r_nxt = rem_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    capture = 1'b1;
                    cnt_nxt = '0;
`ifdef DIV_ZERO_FASTPATH_EN
                    if (bus.divisor == '0) begin
                        state_nxt = DONE;
                        load_res  = 1'b1;
                        res_q_nxt = DIV_ZERO_Q;
                        res_r_nxt = bus.dividend;
                    end else begin
                        state_nxt = CALC;
                    end
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                step_en = 1'b1;
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == LAST_ITER) begin
                    state_nxt = DONE;
                    load_res  = 1'b1;
                    if (op.div_zero) begin
                        res_q_nxt = DIV_ZERO_Q;
                        res_r_nxt = op.dvd_raw;
                    end else begin
                        res_q_nxt = q_fin;
                        res_r_nxt = r_fin;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Flush overrides everything, including a start in the same cycle
        // and the result load on the last iteration.
        if (bus.flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            capture   = 1'b0;
            step_en   = 1'b0;
            load_res  = 1'b0;
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op    <= '0;
            acc   <= '0;
            rem_r <= '0;
        end else if (capture) begin
            op.neg_q    <= bus.is_signed & (bus.dividend[DIV_W-1] ^ bus.divisor[DIV_W-1]);
            op.neg_r    <= bus.is_signed & bus.dividend[DIV_W-1];
            op.div_zero <= (bus.divisor == '0);
            op.dvd_raw  <= bus.dividend;
            op.div_mag  <= dsr_mag;
            acc         <= dvd_mag[DIV_W-1:0];
            rem_r       <= '0;
        end else if (step_en) begin
            acc   <= acc_nxt;
            rem_r <= next_rem;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo_q <= '0;
            rem_q <= '0;
        end else if (load_res) begin
            quo_q <= res_q_nxt;
            rem_q <= res_r_nxt;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- directed, table-driven bench for div_unit, plus hand-written
// sequences for flush, reset mid-op, start-while-busy and start+flush.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic clk;
    logic resetn;

    div_if bus ();

    div_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    localparam int CALC_LAT = 33;
`ifdef DIV_ZERO_FASTPATH_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    localparam int NVEC = 12;
    vec_t tbl [NVEC];

    int checks = 0;
    int fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic s, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] q,
                                input logic [31:0] r, input int lat);
        vec_t v;
        v.name = n; v.sgn = s; v.a = a; v.b = b; v.q = q; v.r = r; v.lat = lat;
        return v;
    endfunction

    // Issue one op, scramble operands afterwards, watch up to 60 cycles.
    // lat = cycle index (1 = first cycle after start edge) of first done.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int ndone, output bit busy_ok);
        @(negedge clk);
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.is_signed = ~sgn;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        lat = 0; ndone = 0; busy_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (lat == 0) lat = k;
            end
            if ((lat == 0 || lat == k) && !bus.busy) busy_ok = 1'b0;
            if (lat != 0 && k > lat && bus.busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int          lat, nd;
        bit          bok;
        logic [31:0] prev_q, prev_r;

        bus.start = 1'b0; bus.flush = 1'b0; bus.is_signed = 1'b0;
        bus.dividend = '0; bus.divisor = '0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("reset busy", {31'b0, bus.busy}, 32'd0);
        chk("reset done", {31'b0, bus.done}, 32'd0);
        chk("reset quotient", bus.quotient, 32'd0);
        chk("reset remainder", bus.remainder, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        tbl[0]  = mk("u100/7",       1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         CALC_LAT);
        tbl[1]  = mk("s-7/2",        1'b1, 32'hFFFFFFF9,  32'h2,         32'hFFFFFFFD,  32'hFFFFFFFF,  CALC_LAT);
        tbl[2]  = mk("s min/-1",     1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0,         CALC_LAT);
        tbl[3]  = mk("u div0",       1'b0, 32'h12345678,  32'h0,         32'hFFFFFFFF,  32'h12345678,  ZERO_LAT);
        tbl[4]  = mk("s div0",       1'b1, 32'h12345678,  32'h0,         32'hFFFFFFFF,  32'h12345678,  ZERO_LAT);
        tbl[5]  = mk("u max/3",      1'b0, 32'hFFFFFFFF,  32'h3,         32'h55555555,  32'h0,         CALC_LAT);
        tbl[6]  = mk("s 7/-2",       1'b1, 32'h7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'h1,         CALC_LAT);
        tbl[7]  = mk("u max/1",      1'b0, 32'hFFFFFFFF,  32'h1,         32'hFFFFFFFF,  32'h0,         CALC_LAT);
        tbl[8]  = mk("u 5/10",       1'b0, 32'd5,         32'd10,        32'd0,         32'd5,         CALC_LAT);
        tbl[9]  = mk("s-100/-7",     1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  CALC_LAT);
        tbl[10] = mk("u 8000/ffff",  1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h0,         32'h80000000,  CALC_LAT);
        tbl[11] = mk("s min/0",      1'b1, 32'h80000000,  32'h0,         32'hFFFFFFFF,  32'h80000000,  ZERO_LAT);

        for (int i = 0; i < NVEC; i++) begin
            run_op(tbl[i].sgn, tbl[i].a, tbl[i].b, lat, nd, bok);
            chk({tbl[i].name, " quotient"},  bus.quotient,  tbl[i].q);
            chk({tbl[i].name, " remainder"}, bus.remainder, tbl[i].r);
            chk({tbl[i].name, " latency"},   32'(lat),      32'(tbl[i].lat));
            chk({tbl[i].name, " done count"}, 32'(nd),      32'd1);
            chk({tbl[i].name, " busy"},      {31'b0, bok},  32'd1);
        end

        // Flush at cycle 10 of an op: idle next cycle, no done, results held.
        prev_q = tbl[NVEC-1].q;
        prev_r = tbl[NVEC-1].r;
        @(negedge clk);
        bus.is_signed = 1'b0; bus.dividend = 32'hFFFFFFFF; bus.divisor = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush busy", {31'b0, bus.busy}, 32'd0);
        chk("flush done", {31'b0, bus.done}, 32'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("flush no done", 32'(nd), 32'd0);
        chk("flush quotient held", bus.quotient, prev_q);
        chk("flush remainder held", bus.remainder, prev_r);
        run_op(1'b0, 32'hFFFFFFFF, 32'd3, lat, nd, bok);
        chk("restart quotient", bus.quotient, 32'h55555555);
        chk("restart remainder", bus.remainder, 32'h0);
        chk("restart latency", 32'(lat), 32'(CALC_LAT));

        // Start held high while busy: ignored, exactly one done.
        @(negedge clk);
        bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.dividend = 32'd1; bus.divisor = 32'd1;
        nd = 0; lat = 0;
        for (int k = 1; k <= 70; k++) begin
            if (k > 1) @(negedge clk);
            bus.start = (k >= 3 && k <= 20);
            if (bus.done) begin
                nd++;
                if (lat == 0) lat = k;
            end
        end
        chk("busy-start done count", 32'(nd), 32'd1);
        chk("busy-start latency", 32'(lat), 32'(CALC_LAT));
        chk("busy-start quotient", bus.quotient, 32'd14);
        chk("busy-start remainder", bus.remainder, 32'd2);

        // Reset at cycle 20: outputs clear at once, nothing after release.
        @(negedge clk);
        bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midreset busy", {31'b0, bus.busy}, 32'd0);
        chk("midreset done", {31'b0, bus.done}, 32'd0);
        chk("midreset quotient", bus.quotient, 32'd0);
        chk("midreset remainder", bus.remainder, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        nd = 0; bok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) nd++;
            if (bus.busy) bok = 1'b0;
        end
        chk("midreset no done", 32'(nd), 32'd0);
        chk("midreset stays idle", {31'b0, bok}, 32'd1);

        // Start and flush together in IDLE: flush wins.
        @(negedge clk);
        bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
        bus.start = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("start+flush busy", {31'b0, bus.busy}, 32'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("start+flush no done", 32'(nd), 32'd0);
        chk("start+flush quotient", bus.quotient, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
